os_pe_param: RTL
================

Name: os_pe_param

Overview:
- Parametrised output-stationary systolic processing element. Next generation of the fixed 32-bit PE.
- Adds the following over the previous PE:
  - configurable data and accumulator widths
  - per-operand valid flags
  - signed/unsigned mode
  - optional saturation
  - double-buffered result register
  - token-driven result drain chain, so a row of PEs can unload results while the next tile accumulates
- One instance per array cell. A/B flow right/down; results drain along the row.

Parameters:
- DATA_W, 16: operand width.
- ACC_W, 40: accumulator/result width. Must satisfy ACC_W >= 2*DATA_W; elaboration error otherwise.
- SAT, 1: 1 = saturate accumulator on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- cfgSigned  in  1  1 = operands and accumulator are two's complement; must be static during a tile.
- ipA  in  DATA_W  operand from left.
- ipAValid  in  1  ipA qualifier.
- ipB  in  DATA_W  operand from top.
- ipBValid  in  1  ipB qualifier.
- ipClr  in  1  first beat of tile; meaningful only on a MAC beat.
- ipLast  in  1  last beat of tile; meaningful only on a MAC beat.
- opA  out  DATA_W  registered ipA to right neighbour.
- opAValid  out  1  registered ipAValid.
- opB  out  DATA_W  registered ipB to lower neighbour.
- opBValid  out  1  registered ipBValid.
- ipC  in  ACC_W  drained result from upstream neighbour.
- ipCValid  in  1  ipC qualifier.
- ipDrainTok  in  1  drain token from downstream side.
- opC  out  ACC_W  drained result out.
- opCValid  out  1  opC qualifier.
- opDrainTok  out  1  drain token to upstream neighbour.
- opSat  out  1  sticky: saturation/overflow occurred.
- opOvr  out  1  sticky: held result overwritten before drain.
- opErr  out  1  sticky: ipCValid collided with own emission.

Behaviour:
- Reset:
  - While rstn=0 at a rising edge, every output register clears to 0.
  - acc and resReg clear to 0; state goes to EMPTY.
  - Applies mid-tile and mid-drain; the partial sum is discarded.
  - Sticky flags clear only on reset.
- Pass-through:
  - opA/opAValid and opB/opBValid are delayed by exactly 1 cycle, each independently of the other.
  - Data passes even when the matching valid is low.
- MAC beat:
  - A MAC beat occurs when ipAValid && ipBValid.
  - Product is full 2*DATA_W, extended to ACC_W: sign-extended if cfgSigned, else zero-extended.
  - sum = (ipClr ? 0 : acc) + product, computed at ACC_W+1 bits.
  - acc updates at the edge ending the beat; no change on non-MAC cycles.
- Overflow:
  - Detected from the extra bit (unsigned) or sign mismatch (signed).
  - SAT=1: clamp to max/min representable in ACC_W for the mode, and set opSat.
  - SAT=0: wrap, and still set opSat.
- Result capture:
  - On a MAC beat with ipLast, resReg <= final sum (after clamp) and acc <= 0.
  - If the beat has both ipClr and ipLast, it is a single-beat tile.
  - The result is available in resReg on the cycle after the last beat.
- State machine (result buffer):
  - EMPTY -> HOLD on a last beat.
  - HOLD -> EMPTY when a token is consumed.
  - HOLD + last beat without a token: resReg overwritten, opOvr set, stay in HOLD.
  - HOLD + last beat + token in the same cycle: old resReg is emitted, new result captured, stay in HOLD; no overrun.
- Drain, all outputs registered with 1-cycle latency:
  - Token in HOLD: opC <= resReg, opCValid <= 1, opDrainTok <= 1 next cycle.
  - Token in EMPTY: opDrainTok <= 1 with no emission; forwarded unchanged.
  - Otherwise: opC <= ipC and opCValid <= ipCValid.
  - Collision: if ipCValid and own emission fall in the same cycle, own result wins, ipC is dropped and opErr is set.
  - Net effect: a row emits one result per cycle, nearest PE first.
- ipClr/ipLast on non-MAC cycles are ignored.

Decomposition:
- Shared package os_pe_pkg:
  - state enum {EMPTY, HOLD}
  - width-check macro/function
  - saturation bound functions sat_max(ACC_W, signed) and sat_min(ACC_W, signed)
- Sub-module os_mac, combinational:
  - inputs: operands, acc, clr, cfgSigned
  - outputs: clamped sum and overflow flag
- os_pe_param holds all registers, the FSM and the drain mux.

Test Plan:
- Reset: DATA_W=8/ACC_W=18, drive random inputs while rstn=0 for 3 cycles -> every output is 0 on each cycle; state is EMPTY.
- Unsigned dot product: 4 beats with A=1,2,3,4 and B=5,6,7,8, ipClr on beat 1, ipLast on beat 4; token 2 cycles later -> opC=70 and opCValid=1 one cycle after the token; opDrainTok=1 in that same cycle; opA/opB echo the inputs with 1-cycle lag.
- Signed mode: single beat A=0xFD, B=7, ipClr+ipLast.
  - cfgSigned=1: drained opC=0x3FFEB (-21).
  - Repeat with cfgSigned=0: opC=1771.
- Saturation: 5 beats of 255*255, unsigned.
  - SAT=1: opC=262143 and opSat=1.
  - SAT=0: opC=62981 and opSat=1.
- Double buffer/overrun:
  - tile1=10 is captured; tile2=20 completes with no token -> opOvr=1; drain yields 20.
  - Separately, last beat and token in the same cycle -> emits tile1, holds tile2, opOvr=0.
- Chain and reset mid-op:
  - 3-PE row all in HOLD with 1, 2, 3; token into PE0 -> opC of the last PE shows 1, 2, 3 on consecutive cycles.
  - rstn pulse after 2 beats of a tile -> acc cleared; a subsequent token is forwarded with no emission.

Source files
------------

// File: rtl/os_pe_pkg.sv
// Shared types and helpers for the output-stationary PE: result-buffer state,
// parameter sanity check and accumulator saturation bounds.
package os_pe_pkg;

  // Result buffer occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } bufState_t;

  // Widest accumulator the bound helpers can describe.
  localparam int MAX_ACC_W = 128;

  // A full-width product must fit the accumulator without loss.
  function automatic bit width_ok(input int dataW, input int accW);
    return (dataW > 0) && (accW >= 2 * dataW) && (accW <= MAX_ACC_W);
  endfunction

  // Largest representable accumulator value; callers truncate to accW bits.
  function automatic logic [MAX_ACC_W-1:0] sat_max(input int accW, input logic sgn);
    int shift;
    shift = sgn ? accW - 1 : accW;
    return (MAX_ACC_W'(1) << shift) - MAX_ACC_W'(1);
  endfunction

  // Smallest representable accumulator value; callers truncate to accW bits.
  function automatic logic [MAX_ACC_W-1:0] sat_min(input int accW, input logic sgn);
    return sgn ? (MAX_ACC_W'(1) << (accW - 1)) : '0;
  endfunction

endpackage

// File: rtl/os_mac.sv
// Combinational multiply-accumulate step: full-width product, optional restart,
// one guard bit for overflow detection and optional clamping.
module os_mac
  import os_pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int SAT    = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc,
  input  logic              clr,
  input  logic              cfgSigned,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = ACC_W + 1;

  localparam logic [ACC_W-1:0] MAX_U = ACC_W'(sat_max(ACC_W, 1'b0));
  localparam logic [ACC_W-1:0] MAX_S = ACC_W'(sat_max(ACC_W, 1'b1));
  localparam logic [ACC_W-1:0] MIN_S = ACC_W'(sat_min(ACC_W, 1'b1));

  logic [PW-1:0] aExt;
  logic [PW-1:0] bExt;
  logic [PW-1:0] prod;
  logic [SW-1:0] prodExt;
  logic [SW-1:0] accExt;
  logic [SW-1:0] rawSum;

  // Extend operands per mode, add at ACC_W+1 bits and clamp on overflow.
  always_comb begin
    // NOTE: every output is assigned before any condition, so no latch is inferred.
    sum     = '0;
    ovf     = 1'b0;
    // The low PW bits of a product of sign-extended operands are the signed product.
    aExt    = {{DATA_W{cfgSigned & a[DATA_W-1]}}, a};
    bExt    = {{DATA_W{cfgSigned & b[DATA_W-1]}}, b};
    prod    = aExt * bExt;
    prodExt = {{(SW - PW){cfgSigned & prod[PW-1]}}, prod};
    accExt  = clr ? '0 : {cfgSigned & acc[ACC_W-1], acc};
    rawSum  = accExt + prodExt;
    // Unsigned overflow is a carry out; signed overflow is a guard/sign mismatch.
    ovf     = cfgSigned ? (rawSum[SW-1] ^ rawSum[SW-2]) : rawSum[SW-1];
    sum     = rawSum[ACC_W-1:0];
    if (SAT != 0 && ovf) begin
      if (cfgSigned) sum = rawSum[SW-1] ? MIN_S : MAX_S;
      else           sum = MAX_U;
    end
  end

endmodule

// File: rtl/os_pe_param.sv
// Output-stationary systolic PE: operand pass-through, accumulator with a
// double-buffered result register and a token-driven result drain chain.
module os_pe_param
  import os_pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfgSigned,
  input  logic [DATA_W-1:0] ipA,
  input  logic              ipAValid,
  input  logic [DATA_W-1:0] ipB,
  input  logic              ipBValid,
  input  logic              ipClr,
  input  logic              ipLast,
  output logic [DATA_W-1:0] opA,
  output logic              opAValid,
  output logic [DATA_W-1:0] opB,
  output logic              opBValid,
  input  logic [ACC_W-1:0]  ipC,
  input  logic              ipCValid,
  input  logic              ipDrainTok,
  output logic [ACC_W-1:0]  opC,
  output logic              opCValid,
  output logic              opDrainTok,
  output logic              opSat,
  output logic              opOvr,
  output logic              opErr
);

  if (!width_ok(DATA_W, ACC_W)) begin : gWidthCheck
    $error("os_pe_param: ACC_W=%0d must be at least 2*DATA_W=%0d", ACC_W, 2 * DATA_W);
  end

  bufState_t        state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] resReg;
  logic [ACC_W-1:0] macSum;
  logic             macOvf;
  logic             macBeat;
  logic             lastBeat;
  logic             emit;

  assign macBeat  = ipAValid & ipBValid;
  assign lastBeat = macBeat & ipLast;
  assign emit     = ipDrainTok & (state == HOLD);

  os_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SAT    (SAT)
  ) uMac (
    .a         (ipA),
    .b         (ipB),
    .acc       (acc),
    .clr       (ipClr),
    .cfgSigned (cfgSigned),
    .sum       (macSum),
    .ovf       (macOvf)
  );

  // Forward operands and their qualifiers to the neighbours one cycle later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      opA      <= '0;
      opAValid <= 1'b0;
      opB      <= '0;
      opBValid <= 1'b0;
    end else begin
      opA      <= ipA;
      opAValid <= ipAValid;
      opB      <= ipB;
      opBValid <= ipBValid;
    end
  end

  // Accumulate MAC beats, capture finished tiles and track result-buffer occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: resReg is a single register rather than a memory array, so it is reset with the rest of the state.
      state  <= EMPTY;
      acc    <= '0;
      resReg <= '0;
      opSat  <= 1'b0;
      opOvr  <= 1'b0;
    end else begin
      if (macBeat) begin
        acc <= lastBeat ? '0 : macSum;
        if (macOvf) opSat <= 1'b1;
      end
      if (lastBeat) begin
        resReg <= macSum;
        state  <= HOLD;
        // A held result lost without ever being drained is an overrun.
        if (state == HOLD && !ipDrainTok) opOvr <= 1'b1;
      end else if (emit) begin
        state <= EMPTY;
      end
    end
  end

  // Drain mux: emit the held result on a token, otherwise pass the upstream result on.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      opC        <= '0;
      opCValid   <= 1'b0;
      opDrainTok <= 1'b0;
      opErr      <= 1'b0;
    end else begin
      opDrainTok <= ipDrainTok;
      if (emit) begin
        // NOTE: non-blocking assignment, so this reads resReg from before a same-edge capture.
        opC      <= resReg;
        opCValid <= 1'b1;
        if (ipCValid) opErr <= 1'b1;
      end else begin
        opC      <= ipC;
        opCValid <= ipCValid;
      end
    end
  end

endmodule
